// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin sensor, enable, vend/refund request and status bundle
interface coin_acceptor_if #(parameter int CREDIT_W = 9);
  logic [3:0]          coin_in;
  logic                enable;
  logic                vend_req;
  logic [CREDIT_W-1:0] vend_price;
  logic                refund_req;
  logic [CREDIT_W-1:0] credit;
  logic                coin_rej;
  logic                vend_ok;
  logic                vend_fail;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amt;
  logic                busy;
  modport master (
    output coin_in, enable, vend_req, vend_price, refund_req,
    input  credit, coin_rej, vend_ok, vend_fail, refund_valid, refund_amt, busy
  );
  modport slave (
    input  coin_in, enable, vend_req, vend_price, refund_req,
    output credit, coin_rej, vend_ok, vend_fail, refund_valid, refund_amt, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronised coin detection, saturating credit, vend and refund service
module coin_acceptor #(
  parameter int CREDIT_W   = 9,
  parameter int MAX_CREDIT = 300,
  parameter int VAL0       = 10,
  parameter int VAL1       = 20,
  parameter int VAL2       = 50,
  parameter int VAL3       = 100
) (
  input logic clk,
  input logic rst,
  coin_acceptor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VEND, REFUND} state_t;
  localparam logic [CREDIT_W:0] V0   = (CREDIT_W+1)'(VAL0);
  localparam logic [CREDIT_W:0] V1   = (CREDIT_W+1)'(VAL1);
  localparam logic [CREDIT_W:0] V2   = (CREDIT_W+1)'(VAL2);
  localparam logic [CREDIT_W:0] V3   = (CREDIT_W+1)'(VAL3);
  localparam logic [CREDIT_W:0] VMAX = (CREDIT_W+1)'(MAX_CREDIT);
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q, dly_q, edge_w;
  logic [CREDIT_W-1:0] credit_q, credit_d, price_q, price_d, refund_amt_q, refund_amt_d;
  logic coin_rej_q, coin_rej_d, vend_ok_q, vend_ok_d, vend_fail_q, vend_fail_d;
  logic refund_valid_q, refund_valid_d;
  logic multi, coin_ok;
  logic [CREDIT_W:0] coin_val, sum;
  assign edge_w   = sync2_q & ~dly_q;
  assign multi    = (edge_w & (edge_w - 4'd1)) != 4'd0;
  assign coin_val = edge_w[0] ? V0 : edge_w[1] ? V1 : edge_w[2] ? V2 : edge_w[3] ? V3 : '0;
  // Sum one bit wider than credit so the saturation test cannot wrap
  assign sum      = {1'b0, credit_q} + coin_val;
  assign coin_ok  = |edge_w && !multi && bus.enable && state_q == IDLE && sum <= VMAX;
  assign coin_rej_d = |edge_w && !coin_ok;
  always_comb begin
    state_d        = state_q;
    credit_d       = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
    price_d        = price_q;
    vend_ok_d      = 1'b0;
    vend_fail_d    = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = refund_amt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.refund_req) state_d = REFUND;
        else if (bus.vend_req) begin
          state_d = VEND;
          price_d = bus.vend_price;
        end
      end
      VEND: begin
        state_d = IDLE;
        if (credit_q >= price_q) begin
          credit_d  = credit_q - price_q;
          vend_ok_d = 1'b1;
        end else vend_fail_d = 1'b1;
      end
      REFUND: begin
        state_d        = IDLE;
        refund_amt_d   = credit_q;
        refund_valid_d = 1'b1;
        credit_d       = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Sensor flops reset high so a coin held through reset is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '1;
      sync2_q        <= '1;
      dly_q          <= '1;
      state_q        <= IDLE;
      credit_q       <= '0;
      price_q        <= '0;
      refund_amt_q   <= '0;
      coin_rej_q     <= 1'b0;
      vend_ok_q      <= 1'b0;
      vend_fail_q    <= 1'b0;
      refund_valid_q <= 1'b0;
    end else begin
      sync1_q        <= bus.coin_in;
      sync2_q        <= sync1_q;
      dly_q          <= sync2_q;
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      refund_amt_q   <= refund_amt_d;
      coin_rej_q     <= coin_rej_d;
      vend_ok_q      <= vend_ok_d;
      vend_fail_q    <= vend_fail_d;
      refund_valid_q <= refund_valid_d;
    end
  end
  assign bus.credit       = credit_q;
  assign bus.coin_rej     = coin_rej_q;
  assign bus.vend_ok      = vend_ok_q;
  assign bus.vend_fail    = vend_fail_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.refund_amt   = refund_amt_q;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vectors with hand-computed expectations for coin_acceptor
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  coin_acceptor_if #(.CREDIT_W(9)) bus();
  coin_acceptor dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic coin_pulse(input logic [3:0] m);
    bus.coin_in = m;
    repeat (3) tick();
    bus.coin_in = 4'b0;
  endtask
  task automatic settle();
    repeat (3) tick();
  endtask
  task automatic add(input logic [3:0] m, input int exp_credit);
    coin_pulse(m);
    chk("add_rej", bus.coin_rej, 0);
    chk("add_credit", bus.credit, exp_credit);
    settle();
  endtask
  task automatic req(input logic v, input logic r, input int price);
    bus.vend_req   = v;
    bus.refund_req = r;
    bus.vend_price = 9'(price);
    tick();
    bus.vend_req   = 1'b0;
    bus.refund_req = 1'b0;
    tick();
  endtask
  initial begin
    bus.coin_in = 4'b0; bus.enable = 1'b1; bus.vend_req = 1'b0;
    bus.vend_price = '0; bus.refund_req = 1'b0;
    repeat (2) tick();
    chk("rst_credit", bus.credit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", {bus.coin_rej, bus.vend_ok, bus.vend_fail, bus.refund_valid}, 0);
    chk("rst_amt", bus.refund_amt, 0);
    rst = 1'b0;
    repeat (3) tick();
    // T1: latency of three edges, single increment for a held level
    bus.coin_in = 4'b0100;
    repeat (2) tick();
    chk("t1_early", bus.credit, 0);
    tick();
    chk("t1_credit", bus.credit, 50);
    repeat (2) tick();
    bus.coin_in = 4'b0;
    settle();
    chk("t1_single", bus.credit, 50);
    // T2: saturation
    add(4'b1000, 150); add(4'b1000, 250); add(4'b0010, 270); add(4'b0001, 280);
    coin_pulse(4'b0100);
    chk("t2_rej", bus.coin_rej, 1);
    chk("t2_hold", bus.credit, 280);
    tick();
    chk("t2_rej_pulse", bus.coin_rej, 0);
    settle();
    add(4'b0010, 300);
    coin_pulse(4'b0001);
    chk("t2_max_rej", bus.coin_rej, 1);
    chk("t2_max_hold", bus.credit, 300);
    settle();
    req(1'b0, 1'b1, 0);
    chk("t2_refund_amt", bus.refund_amt, 300);
    chk("t2_refund_credit", bus.credit, 0);
    // T3: vend success, failure and zero price
    add(4'b1000, 100); add(4'b0010, 120);
    bus.vend_req = 1'b1; bus.vend_price = 9'd100;
    tick();
    chk("t3_busy", bus.busy, 1);
    bus.vend_req = 1'b0;
    tick();
    chk("t3_ok", bus.vend_ok, 1);
    chk("t3_nofail", bus.vend_fail, 0);
    chk("t3_credit", bus.credit, 20);
    tick();
    chk("t3_ok_pulse", bus.vend_ok, 0);
    req(1'b1, 1'b0, 50);
    chk("t3_fail", {bus.vend_ok, bus.vend_fail}, 2'b01);
    chk("t3_fail_credit", bus.credit, 20);
    req(1'b1, 1'b0, 0);
    chk("t3_zero_ok", {bus.vend_ok, bus.vend_fail}, 2'b10);
    chk("t3_zero_credit", bus.credit, 20);
    // T4: refund wins over vend
    add(4'b0100, 70);
    req(1'b1, 1'b1, 10);
    chk("t4_valid", bus.refund_valid, 1);
    chk("t4_amt", bus.refund_amt, 70);
    chk("t4_credit", bus.credit, 0);
    chk("t4_novend", {bus.vend_ok, bus.vend_fail}, 0);
    tick();
    chk("t4_valid_pulse", bus.refund_valid, 0);
    chk("t4_amt_held", bus.refund_amt, 70);
    req(1'b0, 1'b1, 0);
    chk("t4_zero_valid", bus.refund_valid, 1);
    chk("t4_zero_amt", bus.refund_amt, 0);
    // T5: reject paths
    bus.enable = 1'b0;
    coin_pulse(4'b0001);
    chk("t5_dis_rej", bus.coin_rej, 1);
    chk("t5_dis_credit", bus.credit, 0);
    settle();
    bus.enable = 1'b1;
    coin_pulse(4'b0011);
    chk("t5_multi_rej", bus.coin_rej, 1);
    chk("t5_multi_credit", bus.credit, 0);
    settle();
    add(4'b1000, 100);
    bus.coin_in = 4'b0001;
    tick();
    req(1'b1, 1'b0, 0);
    bus.coin_in = 4'b0;
    chk("t5_vend_rej", bus.coin_rej, 1);
    chk("t5_vend_ok", bus.vend_ok, 1);
    chk("t5_vend_credit", bus.credit, 100);
    settle();
    // coin accepted alongside vend_req feeds the VEND compare
    bus.coin_in = 4'b0001;
    repeat (2) tick();
    req(1'b1, 1'b0, 110);
    bus.coin_in = 4'b0;
    chk("t5_same_ok", {bus.vend_ok, bus.vend_fail}, 2'b10);
    chk("t5_same_credit", bus.credit, 0);
    settle();
    // T6: reset behaviour
    bus.coin_in = 4'b1000;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_held_credit", bus.credit, 0);
    chk("t6_held_rej", bus.coin_rej, 0);
    bus.coin_in = 4'b0;
    settle();
    add(4'b0100, 50);
    bus.vend_req = 1'b1; bus.vend_price = 9'd10;
    tick();
    bus.vend_req = 1'b0;
    chk("t6_pre_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_credit", bus.credit, 0);
    chk("t6_pulses", {bus.coin_rej, bus.vend_ok, bus.vend_fail, bus.refund_valid}, 0);
    tick();
    chk("t6_no_pulse", {bus.vend_ok, bus.vend_fail}, 0);
    rst = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
